// File: rtl/dplca_pkg.sv
// Shared DPLCA definitions: state encodings and control constants used by the
// TXOP claim table writer and the DPLCA state diagram.
package dplca_pkg;

    localparam int DPLCA_ID_W = 8;

    typedef enum logic [1:0] {
        ST_DISABLED    = 2'b00,
        ST_WAIT_BEACON = 2'b01,
        ST_RUN         = 2'b10
    } dplca_state_e;

    localparam logic ON   = 1'b1;
    localparam logic OFF  = 1'b0;
    localparam logic OK   = 1'b1;
    localparam logic FAIL = 1'b0;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BEACON = 2'd1,
        COMMIT = 2'd2
    } dplca_ctrl_e;

endpackage

// File: rtl/dplca_age_counter.sv
// Counts PLCA cycles inside the current aging window and flags the beacon that
// closes it. An aging_cycles value of 0 behaves as a one-cycle window.
module dplca_age_counter #(
    parameter int AGE_W = 16
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_beacon_det,
    input  logic             i_dplca_aging,
    input  logic [AGE_W-1:0] i_aging_cycles,
    output logic             o_rotate,
    output logic [AGE_W-1:0] o_age_cnt
);

    logic [AGE_W-1:0] r_age_cnt;
    logic [AGE_W-1:0] w_limit;

    assign w_limit   = (i_aging_cycles == '0) ? AGE_W'(1) : i_aging_cycles;
    assign o_rotate  = i_beacon_det & i_dplca_aging & (r_age_cnt >= w_limit);
    assign o_age_cnt = r_age_cnt;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_age_cnt <= '0;
        end else if (i_load) begin
            r_age_cnt <= AGE_W'(1);
        end else if (i_beacon_det & i_dplca_aging) begin
            if (o_rotate) begin
                r_age_cnt <= AGE_W'(1);
            end else if (r_age_cnt != '1) begin
                // Saturate so a huge window never wraps back to an early count.
                r_age_cnt <= r_age_cnt + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/dplca_txop_table.sv
// Writer side of the DPLCA TXOP claim table: records claimed TXOP IDs into a
// working bitmap and rotates it into a published bitmap once per aging window.
module dplca_txop_table
    import dplca_pkg::*;
#(
    parameter int TABLE_SIZE = 256,
    parameter int AGE_W      = 16
) (
    input  logic                  clk,
    input  logic                  plca_reset,
    input  logic                  dplca_en,
    input  logic                  plca_en,
    input  logic                  dplca_aging,
    input  logic                  beacon_det,
    input  logic [7:0]            beacon_node_count,
    input  logic                  txop_end,
    input  logic [7:0]            txop_id,
    input  logic                  txop_active,
    input  logic [AGE_W-1:0]      aging_cycles,
    output logic [TABLE_SIZE-1:0] txop_claim_table,
    output logic                  dplca_txop_table_upd,
    output logic [7:0]            dplca_txop_id,
    output logic [7:0]            dplca_txop_node_count,
    output logic                  dplca_new_age
);

    dplca_state_e r_state;
    dplca_state_e w_state_next;

    logic [TABLE_SIZE-1:0] r_working;
    logic [TABLE_SIZE-1:0] r_published;
    logic [TABLE_SIZE-1:0] r_table;
    logic [TABLE_SIZE-1:0] w_set;
    logic [TABLE_SIZE-1:0] w_working_wr;
    logic [TABLE_SIZE-1:0] w_working_next;
    logic [TABLE_SIZE-1:0] w_published_next;

    logic                  r_upd;
    logic                  r_new_age;
    logic [7:0]            r_txop_id;
    logic [7:0]            r_node_count;

    logic                  w_clear;
    logic                  w_run;
    logic                  w_start;
    logic                  w_tick;
    logic                  w_rotate;
    logic [AGE_W-1:0]      w_age_cnt;
    logic                  w_unused_age;

    assign w_clear = plca_reset | ~dplca_en | ~plca_en;
    assign w_run   = (r_state == ST_RUN);
    assign w_start = (r_state == ST_WAIT_BEACON) & beacon_det;
    assign w_tick  = w_run & beacon_det;

    dplca_age_counter #(
        .AGE_W (AGE_W)
    ) u_age_counter (
        .clk            (clk),
        .i_clear        (w_clear),
        .i_load         (w_start),
        .i_beacon_det   (w_tick),
        .i_dplca_aging  (dplca_aging),
        .i_aging_cycles (aging_cycles),
        .o_rotate       (w_rotate),
        .o_age_cnt      (w_age_cnt)
    );

    // The window count is only needed inside the counter for the rotate decision.
    assign w_unused_age = ^w_age_cnt;

    // One decoder bit per table entry; only an active TXOP in RUN sets its bit.
    generate
        for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_set
            assign w_set[gi] = w_run & txop_end & txop_active & (txop_id == 8'(gi));
        end
    endgenerate

    // The TXOP write lands before rotation so a claim on a rotating beacon is published.
    assign w_working_wr     = r_working | w_set;
    assign w_working_next   = w_rotate ? '0 : w_working_wr;
    assign w_published_next = w_rotate ? w_working_wr : r_published;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_DISABLED:    w_state_next = ST_WAIT_BEACON;
            ST_WAIT_BEACON: if (beacon_det) w_state_next = ST_RUN;
            ST_RUN:         w_state_next = ST_RUN;
            default:        w_state_next = ST_DISABLED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= ST_DISABLED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_working    <= '0;
            r_published  <= '0;
            r_table      <= '0;
            r_upd        <= OFF;
            r_new_age    <= OFF;
            r_txop_id    <= '0;
            r_node_count <= '0;
        end else begin
            r_working   <= w_working_next;
            r_published <= w_published_next;
            r_table     <= w_working_next | w_published_next;
            r_upd       <= w_run & txop_end;
            if (w_run & txop_end) begin
                r_txop_id <= txop_id;
            end
            if (w_start | w_tick) begin
                r_node_count <= beacon_node_count;
            end
            if (w_tick) begin
                r_new_age <= w_rotate;
            end
        end
    end

    assign txop_claim_table      = r_table;
    assign dplca_txop_table_upd  = r_upd;
    assign dplca_txop_id         = r_txop_id;
    assign dplca_txop_node_count = r_node_count;
    assign dplca_new_age         = r_new_age;

endmodule

// File: tb/tb_dplca_txop_table.sv
// Scoreboard bench for the DPLCA TXOP claim table writer: a behavioural model
// queues expected outputs per driven cycle, compared one clock later.
module tb_dplca_txop_table;

    logic         clk = 1'b0;
    logic         plca_reset;
    logic         dplca_en;
    logic         plca_en;
    logic         dplca_aging;
    logic         beacon_det;
    logic [7:0]   beacon_node_count;
    logic         txop_end;
    logic [7:0]   txop_id;
    logic         txop_active;
    logic [15:0]  aging_cycles;
    logic [255:0] txop_claim_table;
    logic         dplca_txop_table_upd;
    logic [7:0]   dplca_txop_id;
    logic [7:0]   dplca_txop_node_count;
    logic         dplca_new_age;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic         upd;
        logic [7:0]   id;
        logic [7:0]   nc;
        logic         new_age;
        logic [255:0] tbl;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int           m_state = 0;
    logic [255:0] m_work  = '0;
    logic [255:0] m_pub   = '0;
    int           m_age   = 0;
    logic         m_upd   = 1'b0;
    logic         m_new_age = 1'b0;
    logic [7:0]   m_id    = '0;
    logic [7:0]   m_nc    = '0;

    dplca_txop_table dut (
        .clk                   (clk),
        .plca_reset            (plca_reset),
        .dplca_en              (dplca_en),
        .plca_en               (plca_en),
        .dplca_aging           (dplca_aging),
        .beacon_det            (beacon_det),
        .beacon_node_count     (beacon_node_count),
        .txop_end              (txop_end),
        .txop_id               (txop_id),
        .txop_active           (txop_active),
        .aging_cycles          (aging_cycles),
        .txop_claim_table      (txop_claim_table),
        .dplca_txop_table_upd  (dplca_txop_table_upd),
        .dplca_txop_id         (dplca_txop_id),
        .dplca_txop_node_count (dplca_txop_node_count),
        .dplca_new_age         (dplca_new_age)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int lim;
        if (plca_reset || !dplca_en || !plca_en) begin
            m_state = 0; m_work = '0; m_pub = '0; m_age = 0;
            m_upd = 1'b0; m_new_age = 1'b0; m_id = '0; m_nc = '0;
        end else begin
            m_upd = 1'b0;
            case (m_state)
                0: m_state = 1;
                1: if (beacon_det) begin
                    m_nc = beacon_node_count; m_age = 1; m_state = 2;
                end
                default: begin
                    if (txop_end) begin
                        m_upd = 1'b1;
                        m_id  = txop_id;
                        if (txop_active) m_work[txop_id] = 1'b1;
                    end
                    if (beacon_det) begin
                        m_nc = beacon_node_count;
                        lim = (aging_cycles == 16'd0) ? 1 : int'(aging_cycles);
                        if (dplca_aging && m_age >= lim) begin
                            m_pub = m_work; m_work = '0; m_age = 1; m_new_age = 1'b1;
                        end else begin
                            m_new_age = 1'b0;
                            if (dplca_aging && m_age < 65535) m_age++;
                        end
                    end
                end
            endcase
        end
        sb.push_back('{m_upd, m_id, m_nc, m_new_age, m_work | m_pub});
    endtask

    task automatic step();
        exp_t e;
        logic ev;
        ev = beacon_det | txop_end;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("upd",      256'(dplca_txop_table_upd),  256'(e.upd));
        chk("txop_id",  256'(dplca_txop_id),         256'(e.id));
        chk("node_cnt", 256'(dplca_txop_node_count), 256'(e.nc));
        chk("new_age",  256'(dplca_new_age),         256'(e.new_age));
        chk("table",    txop_claim_table,            e.tbl);
        if (ev)
            $display("txn t=%0t beacon=%0b txop_end=%0b id=%0d act=%0b -> upd=%0b new_age=%0b nc=%0d",
                     $time, beacon_det, txop_end, txop_id, txop_active,
                     dplca_txop_table_upd, dplca_new_age, dplca_txop_node_count);
    endtask

    task automatic cyc(input logic b, input logic [7:0] bnc, input logic te,
                       input logic [7:0] tid, input logic ta);
        beacon_det = b; beacon_node_count = bnc;
        txop_end = te; txop_id = tid; txop_active = ta;
        step();
        beacon_det = 1'b0; txop_end = 1'b0; txop_active = 1'b0;
    endtask

    task automatic beacon(input logic [7:0] nc);
        cyc(1'b1, nc, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic claim(input logic [7:0] id, input logic act);
        cyc(1'b0, 8'd0, 1'b1, id, act);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        plca_reset = 1'b1; dplca_en = 1'b1; plca_en = 1'b1;
        dplca_aging = 1'b1; aging_cycles = 16'd2;
        beacon_det = 1'b0; beacon_node_count = '0;
        txop_end = 1'b0; txop_id = '0; txop_active = 1'b0;
        idle(2);
        chk("rst_table", txop_claim_table, '0);
        chk("rst_upd", 256'(dplca_txop_table_upd), 256'(0));

        // Claim path, then reset mid-RUN
        plca_reset = 1'b0;
        idle(1);
        beacon(8'd8);
        claim(8'd3, 1'b1);
        chk("claim_upd", 256'(dplca_txop_table_upd), 256'(1));
        chk("claim_id", 256'(dplca_txop_id), 256'(3));
        chk("claim_bit3", 256'(txop_claim_table[3]), 256'(1));
        chk("claim_nc", 256'(dplca_txop_node_count), 256'(8));
        claim(8'd7, 1'b1);
        plca_reset = 1'b1;
        claim(8'd9, 1'b1);
        chk("reset_table", txop_claim_table, '0);
        chk("reset_upd", 256'(dplca_txop_table_upd), 256'(0));
        chk("reset_new_age", 256'(dplca_new_age), 256'(0));
        plca_reset = 1'b0;

        // Same with dplca_en low; claims while in WAIT_BEACON are ignored
        idle(1);
        claim(8'd11, 1'b1);
        chk("wait_ignores_txop", 256'(txop_claim_table[11]), 256'(0));
        beacon(8'd4);
        claim(8'd3, 1'b1);
        claim(8'd7, 1'b1);
        dplca_en = 1'b0;
        claim(8'd9, 1'b1);
        chk("den_table", txop_claim_table, '0);
        chk("den_upd", 256'(dplca_txop_table_upd), 256'(0));
        dplca_en = 1'b1;

        // Aging with a two-cycle window
        idle(1);
        beacon(8'd5);
        claim(8'd5, 1'b1);
        claim(8'd6, 1'b0);
        chk("inactive_upd", 256'(dplca_txop_table_upd), 256'(1));
        chk("inactive_bit6", 256'(txop_claim_table[6]), 256'(0));
        idle(2);
        beacon(8'd5);
        chk("age_b2_new_age", 256'(dplca_new_age), 256'(0));
        idle(2);
        beacon(8'd5);
        chk("age_b3_new_age", 256'(dplca_new_age), 256'(1));
        chk("age_b3_bit5", 256'(txop_claim_table[5]), 256'(1));
        claim(8'd255, 1'b1);
        claim(8'd254, 1'b1);
        chk("b2b_id", 256'(dplca_txop_id), 256'(254));
        chk("id255_bit", 256'(txop_claim_table[255]), 256'(1));
        beacon(8'd5);
        chk("age_b4_new_age", 256'(dplca_new_age), 256'(0));
        chk("age_b4_bit5", 256'(txop_claim_table[5]), 256'(1));
        beacon(8'd5);
        chk("age_b5_bit5", 256'(txop_claim_table[5]), 256'(0));

        // Aging disabled
        dplca_aging = 1'b0;
        claim(8'd20, 1'b1);
        for (int i = 0; i < 10; i++) begin
            beacon(8'd6);
            chk("noage_new_age", 256'(dplca_new_age), 256'(0));
            chk("noage_bit20", 256'(txop_claim_table[20]), 256'(1));
        end

        // Claim coinciding with a rotating beacon
        dplca_aging = 1'b1;
        plca_en = 1'b0;
        idle(1);
        plca_en = 1'b1;
        idle(1);
        beacon(8'd3);
        beacon(8'd3);
        cyc(1'b1, 8'd3, 1'b1, 8'd9, 1'b1);
        chk("coll_upd", 256'(dplca_txop_table_upd), 256'(1));
        chk("coll_new_age", 256'(dplca_new_age), 256'(1));
        chk("coll_bit9", 256'(txop_claim_table[9]), 256'(1));
        beacon(8'd3);
        chk("coll_pub_bit9", 256'(txop_claim_table[9]), 256'(1));
        beacon(8'd3);
        chk("coll_clear_bit9", 256'(txop_claim_table[9]), 256'(0));

        // aging_cycles of 0 rotates on every beacon
        aging_cycles = 16'd0;
        beacon(8'd2);
        claim(8'd40, 1'b1);
        beacon(8'd2);
        chk("zero_new_age", 256'(dplca_new_age), 256'(1));
        chk("zero_bit40_pub", 256'(txop_claim_table[40]), 256'(1));
        beacon(8'd2);
        chk("zero_new_age2", 256'(dplca_new_age), 256'(1));
        chk("zero_bit40_gone", 256'(txop_claim_table[40]), 256'(0));

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) aging_cycles = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) dplca_aging = ~dplca_aging;
            plca_en = ($urandom_range(0, 99) != 0);
            cyc(($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)),
                ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
